// File: rtl/w_schedule_stream.sv
// SHA-256 message-schedule stream.
// Loads one 512-bit block, presents the reordered 16-word block on W with a
// one-cycle en_next pulse, then streams W_0..W_{ROUNDS-1} one word per
// accepted transfer. The expansion runs on a 16-word sliding window, so
// W_t is always window[0].
//
// Handshake: a word transfers on every rising edge where w_valid and w_ready
// are both high. w_valid, W_t and t only change after a transfer (or on
// load/reset), so a stalled word is held stable with nothing dropped or
// repeated; w_ready may toggle freely and has no effect while w_valid=0.
module w_schedule_stream #(
  parameter int ROUNDS = 64,
  parameter bit BSWAP  = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [511:0] M,
  output logic [511:0] W,
  output logic         en_next,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  W_t,
  output logic [5:0]   t,
  output logic         busy,
  output logic         done,
  output logic         state_dbg
);

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

  state_t      state;
  logic [31:0] window    [16];
  logic [31:0] load_word [16];
  logic [31:0] next_word;
  logic        load;
  logic        xfer;
  logic        last;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Word i of M sits at the top end; optionally byte-reverse each word.
  for (genvar i = 0; i < 16; i++) begin : g_load
    logic [31:0] raw;
    assign raw          = M[511-32*i -: 32];
    assign load_word[i] = BSWAP ? {raw[7:0], raw[15:8], raw[23:16], raw[31:24]} : raw;
  end

  assign load      = (state == IDLE) && en;
  assign xfer      = (state == STREAM) && w_ready;
  assign last      = xfer && (t == LAST_T);
  // Schedule word t+16 from the window holding words t..t+15.
  assign next_word = sig1(window[14]) + window[9] + sig0(window[1]) + window[0];

  assign w_valid   = (state == STREAM);
  assign busy      = (state == STREAM);
  assign W_t       = window[0];
  assign state_dbg = state;

  // Load/stream state machine with window, index and pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      t       <= '0;
      en_next <= 1'b0;
      done    <= 1'b0;
      W       <= '0;
      for (int i = 0; i < 16; i++) window[i] <= '0;
    end else begin
      en_next <= load;
      done    <= last;
      if (load) begin
        for (int i = 0; i < 16; i++) begin
          window[i]     <= load_word[i];
          W[32*i +: 32] <= load_word[i];
        end
        t     <= '0;
        state <= STREAM;
      end else if (xfer) begin
        for (int i = 0; i < 15; i++) window[i] <= window[i+1];
        window[15] <= next_word;
        if (last) begin
          t     <= '0;
          state <= IDLE;
        end else begin
          t <= t + 6'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_w_schedule_stream.sv
// Bench for w_schedule_stream: three instances (default, byte-swap, 16 rounds),
// a reference schedule computed with the plain SHA-256 recurrence, table
// vectors for known words, and sequences for backpressure, en and reset.
module tb_w_schedule_stream;

  localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] HDR = 512'h02000000_671D0E2F_1E4A3B5C_00000000_8A9BCDEF_12345678_DEADBEEF_0BADF00D_55AA55AA_13579BDF_2468ACE0_FEDCBA98_76543210_C3C3C3C3_30CC0782_15A907C0;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic en0, rdy0, en_next0, valid0, busy0, done0, st0;
  logic [511:0] m0, w0;
  logic [31:0] wt0;
  logic [5:0] t0;
  logic en1, rdy1, en_next1, valid1, busy1, done1, st1;
  logic [511:0] m1, w1;
  logic [31:0] wt1;
  logic [5:0] t1;
  logic en2, rdy2, en_next2, valid2, busy2, done2, st2;
  logic [511:0] m2, w2;
  logic [31:0] wt2;
  logic [5:0] t2;

  w_schedule_stream #(.ROUNDS(64), .BSWAP(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .en(en0), .M(m0), .W(w0), .en_next(en_next0),
    .w_valid(valid0), .w_ready(rdy0), .W_t(wt0), .t(t0), .busy(busy0),
    .done(done0), .state_dbg(st0));
  w_schedule_stream #(.ROUNDS(64), .BSWAP(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .en(en1), .M(m1), .W(w1), .en_next(en_next1),
    .w_valid(valid1), .w_ready(rdy1), .W_t(wt1), .t(t1), .busy(busy1),
    .done(done1), .state_dbg(st1));
  w_schedule_stream #(.ROUNDS(16), .BSWAP(1'b0)) u_dut2 (
    .clk(clk), .reset(reset), .en(en2), .M(m2), .W(w2), .en_next(en_next2),
    .w_valid(valid2), .w_ready(rdy2), .W_t(wt2), .t(t2), .busy(busy2),
    .done(done2), .state_dbg(st2));

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ref_w [64];
  logic [31:0] got_w [64];

  typedef struct {
    logic [511:0] m;
    int           idx;
    logic [31:0]  exp;
  } vec_t;
  vec_t tbl [7];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: textbook schedule recurrence over a flat word array
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic build_ref(input logic [511:0] m, input bit bs, output logic [511:0] wblk);
    logic [31:0] wd;
    for (int i = 0; i < 64; i++) begin
      if (i < 16) begin
        wd = m[511-32*i -: 32];
        if (bs) wd = {<<8{wd}};
        ref_w[i] = wd;
        wblk[32*i +: 32] = wd;
      end else begin
        ref_w[i] = (rotr(ref_w[i-2], 17) ^ rotr(ref_w[i-2], 19) ^ (ref_w[i-2] >> 10))
                 + ref_w[i-7]
                 + (rotr(ref_w[i-15], 7) ^ rotr(ref_w[i-15], 18) ^ (ref_w[i-15] >> 3))
                 + ref_w[i-16];
      end
    end
  endtask

  task automatic fill_queue(input int rounds);
    exp_q.delete();
    for (int i = 0; i < rounds; i++) exp_q.push_back(ref_w[i]);
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // driver: called on a negedge with dut0 idle; returns on the en_next cycle
  task automatic load0(input logic [511:0] m);
    logic [511:0] wb;
    build_ref(m, 1'b0, wb);
    fill_queue(64);
    en0 = 1'b1;
    m0  = m;
    @(negedge clk);
    en0 = 1'b0;
    check("en_next", en_next0, 1);
    check("load_W", w0, wb);
    check("first_t", t0, 0);
    check("first_valid", valid0, 1);
    check("first_busy", busy0, 1);
    check("state_dbg", st0, 1);
  endtask

  // streams dut0 from the current (first-word) negedge to done or abort
  task automatic stream0(input bit rnd, input int pulse_t, input int abort_t,
                         input int hold_t, input logic [511:0] alt_m);
    int n;
    bit fin;
    bit held;
    bit first;
    logic [31:0] pw;
    logic [5:0] pt;
    logic [31:0] e;
    n = 0; fin = 0; held = 0; first = 1; pw = '0; pt = '0;
    for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
      if (done0) begin
        fin = 1;
        check("done_valid", valid0, 0);
        check("done_busy", busy0, 0);
        check("done_t", t0, 0);
        check("done_no_early_load", en_next0, 0);
      end else if (abort_t >= 0 && int'(t0) == abort_t && valid0) begin
        reset = 1'b0;
        #1;
        check("rst_W", w0, 0);
        check("rst_W_t", wt0, 0);
        check("rst_t", t0, 0);
        check("rst_valid", valid0, 0);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_en_next", en_next0, 0);
        fin = 1;
      end else begin
        if (!first) check("en_next_single", en_next0, 0);
        if (held) begin
          check("hold_W_t", wt0, pw);
          check("hold_t", t0, pt);
        end
        check("stream_valid", valid0, 1);
        en0 = (int'(t0) == pulse_t) || (hold_t >= 0 && int'(t0) >= hold_t);
        if (en0) m0 = alt_m;
        rdy0 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rdy0) begin
          if (exp_q.size() == 0) begin
            check("extra_word", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("word%0d", n), wt0, e);
            check($sformatf("t%0d", n), t0, n);
          end
          if (n < 64) got_w[n] = wt0;
          n++;
          held = 0;
        end else begin
          held = 1;
          pw = wt0;
          pt = t0;
        end
        first = 0;
      end
      if (!fin) @(negedge clk);
    end
    if (!fin) check("stream_timeout", 0, 1);
    if (abort_t < 0) check("n_transfers", n, 64);
  endtask

  // stream for dut1 (which=1) or dut2 (which=2) with w_ready held high
  task automatic stream_simple(input int which, input int rounds);
    int n;
    bit fin;
    logic v, d;
    logic [31:0] wt;
    logic [5:0] tt;
    n = 0; fin = 0;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      v  = (which == 1) ? valid1 : valid2;
      d  = (which == 1) ? done1 : done2;
      wt = (which == 1) ? wt1 : wt2;
      tt = (which == 1) ? t1 : t2;
      if (d) begin
        fin = 1;
        check($sformatf("dut%0d_done_t", which), tt, 0);
        check($sformatf("dut%0d_done_valid", which), v, 0);
      end else begin
        if (v) begin
          check($sformatf("dut%0d_word%0d", which, n), wt, (n < 64) ? ref_w[n] : 32'h0);
          check($sformatf("dut%0d_t%0d", which, n), tt, n);
          n++;
        end
        @(negedge clk);
      end
    end
    if (!fin) check($sformatf("dut%0d_timeout", which), 0, 1);
    check($sformatf("dut%0d_n_transfers", which), n, rounds);
  endtask

  initial begin
    logic [511:0] wb;
    logic [511:0] rb;
    reset = 1'b0;
    en0 = 0; en1 = 0; en2 = 0;
    m0 = '0; m1 = '0; m2 = '0;
    rdy0 = 0; rdy1 = 0; rdy2 = 0;

    tbl[0] = '{ABC, 0,  32'h61626380};
    tbl[1] = '{ABC, 15, 32'h00000018};
    tbl[2] = '{ABC, 16, 32'h61626380};
    tbl[3] = '{ABC, 17, 32'h000F0000};
    tbl[4] = '{HDR, 0,  32'h02000000};
    tbl[5] = '{HDR, 1,  32'h671D0E2F};
    tbl[6] = '{HDR, 15, 32'h15A907C0};

    // reset state
    repeat (2) @(negedge clk);
    check("reset_W", w0, 0);
    check("reset_W_t", wt0, 0);
    check("reset_t", t0, 0);
    check("reset_valid", valid0, 0);
    check("reset_busy", busy0, 0);
    check("reset_en_next", en_next0, 0);
    check("reset_done", done0, 0);
    check("reset_state", st0, 0);
    reset = 1'b1;
    @(negedge clk);

    // reorder and header stream
    load0(HDR);
    check("hdr_W_lo", w0[31:0], 32'h02000000);
    check("hdr_W_hi", w0[511:480], 32'h15A907C0);
    check("hdr_W_t0", wt0, 32'h02000000);
    stream0(1'b0, -1, -1, -1, '0);
    @(negedge clk);
    check("done_single", done0, 0);

    // table vectors
    for (int k = 0; k < 7; k++) begin
      load0(tbl[k].m);
      stream0(1'b0, -1, -1, -1, '0);
      check($sformatf("tbl%0d_idx%0d", k, tbl[k].idx), got_w[tbl[k].idx], tbl[k].exp);
    end

    // backpressure on the abc block, then random blocks
    @(negedge clk);
    load0(ABC);
    stream0(1'b1, -1, -1, -1, '0);
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      load0(rand_block());
      stream0(1'b1, -1, -1, -1, '0);
    end

    // en pulse mid-stream is ignored
    @(negedge clk);
    load0(rand_block());
    stream0(1'b0, 5, -1, -1, HDR);

    // en held through done reloads on the done edge
    @(negedge clk);
    load0(ABC);
    stream0(1'b0, -1, -1, 60, HDR);
    @(negedge clk);
    en0 = 1'b0;
    build_ref(HDR, 1'b0, wb);
    fill_queue(64);
    check("reload_en_next", en_next0, 1);
    check("reload_W", w0, wb);
    check("reload_t", t0, 0);
    stream0(1'b0, -1, -1, -1, '0);

    // reset mid-stream abandons the block
    @(negedge clk);
    load0(rand_block());
    stream0(1'b1, -1, 30, -1, '0);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", done0, 0);
      check("abort_idle", valid0, 0);
    end
    reset = 1'b1;
    @(negedge clk);
    load0(ABC);
    stream0(1'b0, -1, -1, -1, '0);

    // byte-swap instance
    @(negedge clk);
    build_ref(HDR, 1'b1, rb);
    en1 = 1'b1;
    m1  = HDR;
    rdy1 = 1'b1;
    @(negedge clk);
    en1 = 1'b0;
    check("bswap_en_next", en_next1, 1);
    check("bswap_W_t0", wt1, 32'h00000002);
    check("bswap_W_hi", w1[511:480], 32'hC007A915);
    check("bswap_W", w1, rb);
    stream_simple(1, 64);

    // 16-round instance
    @(negedge clk);
    build_ref(ABC, 1'b0, wb);
    en2 = 1'b1;
    m2  = ABC;
    rdy2 = 1'b1;
    @(negedge clk);
    en2 = 1'b0;
    check("r16_en_next", en_next2, 1);
    check("r16_W", w2, wb);
    stream_simple(2, 16);
    @(negedge clk);
    check("r16_done_single", done2, 0);
    check("r16_idle", busy2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
